// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a valid/ready request side and a valid/ready
// result side. The block handles one operation at a time.
//
// States:
//   state | meaning
//   IDLE  | IN_READY=1; a request is latched on IN_VALID
//   EXEC  | single-cycle ops compute here; shifts/MUL iterate one bit per cycle
//   DONE  | OUT_VALID=1; RESULT/flags held until OUT_READY
//
// Ports:
//   CLK, RESET_N         clock, asynchronous active-low reset
//   IN_VALID/IN_READY    request handshake
//   DATA1, DATA2, SELECT operands A, B and opcode
//                        (000 FWD, 001 ADD, 010 AND, 011 OR, 100 SUB,
//                         101 SLL, 110 SRL, 111 MUL)
//   OUT_VALID/OUT_READY  result handshake
//   RESULT, ZERO, CARRY, ILLEGAL  registered result and flags
//
// Build option: define ALU_SEQ_MUL_EN to include the shift-add multiplier.
// Without it, opcode 111 completes in one cycle and reports ILLEGAL.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic [2:0]       SELECT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             CARRY,
    output logic             ILLEGAL
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q, zero_q, illegal_q;

    logic [WIDTH-1:0] alu_res, sh_res;
    logic             alu_c, sh_out, is_shift;
    logic [CNT_W-1:0] shamt;

    assign shamt    = b_q[CNT_W-1:0];
    assign is_shift = (op_q == OP_SLL) || (op_q == OP_SRL);

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (op_q)
            OP_FWD:  alu_res = b_q;
            OP_ADD:  {alu_c, alu_res} = {1'b0, a_q} + {1'b0, b_q};
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_SUB:  {alu_c, alu_res} = {1'b0, a_q} - {1'b0, b_q};
            default: alu_res = '0;
        endcase
    end

    // res_q doubles as the shift working register while in EXEC.
    always_comb begin
        if (op_q == OP_SLL) begin
            sh_res = {res_q[WIDTH-2:0], 1'b0};
            sh_out = res_q[WIDTH-1];
        end else begin
            sh_res = {1'b0, res_q[WIDTH-1:1]};
            sh_out = res_q[0];
        end
    end

`ifdef ALU_SEQ_MUL_EN
    // Right-shifting shift-add: {mul_hi_q, res_q} starts as {0, B}; each step
    // adds A to the high half when the current LSB of B is set, then shifts
    // the whole product right by one. After WIDTH steps it holds A*B.
    logic [WIDTH-1:0] mul_hi_q, mul_hi_nxt, mul_lo_nxt;
    logic [WIDTH:0]   mul_sum;

    always_comb begin
        mul_sum    = {1'b0, mul_hi_q} + (res_q[0] ? {1'b0, a_q} : '0);
        mul_hi_nxt = mul_sum[WIDTH:1];
        mul_lo_nxt = {mul_sum[0], res_q[WIDTH-1:1]};
    end
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OP_FWD;
            res_q     <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mul_hi_q  <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (IN_VALID) begin
                        a_q       <= DATA1;
                        b_q       <= DATA2;
                        op_q      <= SELECT;
                        res_q     <= (SELECT == OP_MUL) ? DATA2 : DATA1;
                        carry_q   <= 1'b0;
                        zero_q    <= 1'b0;
                        illegal_q <= 1'b0;
                        // Down-counter: the last iteration runs when cnt_q==0.
                        if (SELECT == OP_MUL)
                            cnt_q <= MUL_LAST;
                        else if (DATA2[CNT_W-1:0] != '0)
                            cnt_q <= DATA2[CNT_W-1:0] - CNT_W'(1);
                        else
                            cnt_q <= '0;
`ifdef ALU_SEQ_MUL_EN
                        mul_hi_q  <= '0;
`endif
                        state_q   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_shift) begin
                        if (shamt == '0) begin
                            zero_q  <= (res_q == '0);
                            state_q <= S_DONE;
                        end else begin
                            res_q   <= sh_res;
                            carry_q <= sh_out;
                            if (cnt_q == '0) begin
                                zero_q  <= (sh_res == '0);
                                state_q <= S_DONE;
                            end else begin
                                cnt_q <= cnt_q - CNT_W'(1);
                            end
                        end
                    end
`ifdef ALU_SEQ_MUL_EN
                    else if (op_q == OP_MUL) begin
                        mul_hi_q <= mul_hi_nxt;
                        res_q    <= mul_lo_nxt;
                        if (cnt_q == '0) begin
                            carry_q <= |mul_hi_nxt;
                            zero_q  <= (mul_lo_nxt == '0);
                            state_q <= S_DONE;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
`else
                    else if (op_q == OP_MUL) begin
                        res_q     <= '0;
                        carry_q   <= 1'b0;
                        zero_q    <= 1'b1;
                        illegal_q <= 1'b1;
                        state_q   <= S_DONE;
                    end
`endif
                    else begin
                        res_q   <= alu_res;
                        carry_q <= alu_c;
                        zero_q  <= (alu_res == '0);
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (OUT_READY)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign IN_READY  = (state_q == S_IDLE);
    assign OUT_VALID = (state_q == S_DONE);
    assign RESULT    = res_q;
    assign ZERO      = zero_q;
    assign CARRY     = carry_q;
    assign ILLEGAL   = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    localparam int W = 8;

    logic         CLK, RESET_N, IN_VALID, IN_READY, OUT_VALID, OUT_READY;
    logic [W-1:0] DATA1, DATA2, RESULT;
    logic [2:0]   SELECT;
    logic         ZERO, CARRY, ILLEGAL;

    alu_seq #(.WIDTH(W)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .DATA1(DATA1), .DATA2(DATA2), .SELECT(SELECT),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .RESULT(RESULT), .ZERO(ZERO), .CARRY(CARRY), .ILLEGAL(ILLEGAL)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         z, c, ill;
        int           acc;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Monitor: pops on the first cycle of each valid window, checks latency,
    // and re-checks RESULT/flags every cycle the result is held.
    initial begin
        exp_t cur;
        bit   have;
        have = 0;
        forever begin
            @(negedge CLK);
            if (RESET_N && OUT_VALID) begin
                if (!have) begin
                    if (sb.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_output: result %0h with nothing expected", RESULT);
                    end else begin
                        cur  = sb.pop_front();
                        have = 1;
                        chk("latency", cyc - cur.acc, cur.lat);
                    end
                end
                if (have) begin
                    chk("result",  RESULT,  cur.res);
                    chk("zero",    ZERO,    cur.z);
                    chk("carry",   CARRY,   cur.c);
                    chk("illegal", ILLEGAL, cur.ill);
                end
                if (OUT_READY) have = 0;
            end else begin
                have = 0;
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] r, input logic c, input logic ill, input int lat);
        exp_t e;
        int   n;
        @(negedge CLK);
        IN_VALID = 1'b1; SELECT = op; DATA1 = a; DATA2 = b;
        n = 0;
        while (!IN_READY && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (!IN_READY) begin
            checks++;
            $display("FAIL accept_timeout: IN_READY stayed %0b", IN_READY);
        end else begin
            e.res = r; e.z = (r == '0); e.c = c; e.ill = ill;
            e.acc = cyc + 1; e.lat = lat;
            sb.push_back(e);
        end
        @(negedge CLK);
        IN_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(sb.size() == 0 && !OUT_VALID && IN_READY) && n < 60) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 60) begin
            checks++;
            $display("FAIL idle_timeout: %0d results outstanding", sb.size());
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, OUT_VALID, 0);
        chk({tag, "_in_ready"},  IN_READY,  1);
        chk({tag, "_result"},    RESULT,    0);
        chk({tag, "_zero"},      ZERO,      0);
        chk({tag, "_carry"},     CARRY,     0);
        chk({tag, "_illegal"},   ILLEGAL,   0);
    endtask

    initial begin
        int n;
        RESET_N = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
        DATA1 = '0; DATA2 = '0; SELECT = 3'b000;
        #1 RESET_N = 1'b0;
        #2 chk_reset_outputs("reset");
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;

        // op, A, B, result, carry, illegal, latency
        send(3'b001, 8'hF0, 8'h20, 8'h10, 1, 0, 1);   // ADD carry-out
        send(3'b100, 8'h05, 8'h05, 8'h00, 0, 0, 1);   // SUB zero
        send(3'b100, 8'h03, 8'h05, 8'hFE, 1, 0, 1);   // SUB borrow
        send(3'b101, 8'h81, 8'h03, 8'h08, 0, 0, 3);   // SLL by 3
        send(3'b110, 8'h81, 8'h00, 8'h81, 0, 0, 1);   // SRL by 0
        send(3'b110, 8'h81, 8'h01, 8'h40, 1, 0, 1);   // SRL by 1
        send(3'b110, 8'h88, 8'h04, 8'h08, 1, 0, 4);   // SRL by 4
        send(3'b101, 8'h81, 8'h07, 8'h80, 0, 0, 7);   // SLL by 7
        send(3'b000, 8'h00, 8'h5A, 8'h5A, 0, 0, 1);   // FWD
        send(3'b010, 8'hF0, 8'h3C, 8'h30, 0, 0, 1);   // AND
        send(3'b011, 8'hF0, 8'h0C, 8'hFC, 0, 0, 1);   // OR
        send(3'b001, 8'hFF, 8'h01, 8'h00, 1, 0, 1);   // ADD wrap to zero
        send(3'b010, 8'hF0, 8'h0F, 8'h00, 0, 0, 1);   // AND zero
`ifdef ALU_SEQ_MUL_EN
        send(3'b111, 8'h10, 8'h11, 8'h10, 1, 0, 8);
        send(3'b111, 8'h03, 8'h05, 8'h0F, 0, 0, 8);
        send(3'b111, 8'hFF, 8'hFF, 8'h01, 1, 0, 8);
`else
        send(3'b111, 8'h10, 8'h11, 8'h00, 0, 1, 1);
`endif
        wait_idle();

        // Result held with OUT_READY low while IN_VALID toggles.
        OUT_READY = 1'b0;
        send(3'b001, 8'h12, 8'h34, 8'h46, 0, 0, 1);
        n = 0;
        while (!OUT_VALID && n < 20) begin
            @(negedge CLK);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            IN_VALID = i[0]; SELECT = 3'b001; DATA1 = 8'h01; DATA2 = 8'h02;
            @(negedge CLK);
            chk("stall_in_ready",  IN_READY,  0);
            chk("stall_out_valid", OUT_VALID, 1);
        end
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        wait_idle();
        repeat (2) begin
            @(negedge CLK);
            chk("no_extra_accept", OUT_VALID, 0);
        end

        // Asynchronous reset in the middle of a MUL.
        send(3'b111, 8'h10, 8'h11,
`ifdef ALU_SEQ_MUL_EN
             8'h10, 1, 0, 8);
`else
             8'h00, 0, 1, 1);
`endif
        repeat (3) @(posedge CLK);
        #2 RESET_N = 1'b0;
        sb.delete();
        #1 chk_reset_outputs("abort");
        @(negedge CLK);
        RESET_N = 1'b1;
        send(3'b001, 8'h01, 8'h01, 8'h02, 0, 0, 1);
        wait_idle();
        chk("scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

endmodule
